// File: rtl/ram_pkg.sv
// Shared definitions for the clearable dual-read RAM: sequencer state encoding
// and Hack-compatible default geometry.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_AWIDTH = 9;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks a pointer across the whole array after reset or on a
// clear request, and owns the write port while doing so.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              wr_en_clr,
    output logic [AWIDTH-1:0] wr_addr_clr
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                // Pointer wraps back to 0 on the same edge that finishes the sweep.
                clr_ptr_d = clr_ptr_q + AWIDTH'(1);
                if (clr_ptr_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign wr_en_clr   = (state_q == ST_CLEAR);
    assign wr_addr_clr = clr_ptr_q;

endmodule

// File: rtl/ram_clr.sv
// Single-write, dual-read RAM with Hack-style combinational reads and a
// built-in clear sweep; reads return 0 while the sweep owns the array.
module ram_clr
    import ram_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [AWIDTH-1:0] address,
    output logic [WIDTH-1:0]  out,
    input  logic [AWIDTH-1:0] address2,
    output logic [WIDTH-1:0]  out2,
    input  logic              clear,
    output logic              busy
);

    localparam int DEPTH = depth_of(AWIDTH);

    logic              wr_en_clr;
    logic [AWIDTH-1:0] wr_addr_clr;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    ram_clr_seq #(
        .AWIDTH (AWIDTH)
    ) u_seq (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .busy        (busy),
        .wr_en_clr   (wr_en_clr),
        .wr_addr_clr (wr_addr_clr)
    );

    // Sequencer wins the write port; a user load competing with clear is dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = in;
        if (reset) begin
            mem_we = 1'b0;
        end else if (wr_en_clr) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr_clr;
            mem_wdata = '0;
        end else if (load && !clear) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        out  = busy ? '0 : mem_q[address];
        out2 = busy ? '0 : mem_q[address2];
    end

endmodule

// File: tb/tb_ram_clr.sv
// Scoreboard bench for ram_clr: a default Hack-sized instance and an 8x16 instance.
module tb_ram_clr;

    logic        clk;
    logic        reset, load, clear, busy;
    logic [15:0] in, out, out2;
    logic [8:0]  address, address2;

    logic        reset8, load8, clear8, busy8;
    logic [7:0]  in8, out8, out2_8;
    logic [3:0]  address8, address2_8;

    logic [15:0] model [512];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    ram_clr u_dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .address  (address),
        .out      (out),
        .address2 (address2),
        .out2     (out2),
        .clear    (clear),
        .busy     (busy)
    );

    ram_clr #(.WIDTH(8), .AWIDTH(4)) u_small (
        .clk      (clk),
        .reset    (reset8),
        .in       (in8),
        .load     (load8),
        .address  (address8),
        .out      (out8),
        .address2 (address2_8),
        .out2     (out2_8),
        .clear    (clear8),
        .busy     (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        step();
        load     = 1'b0;
        model[a] = d;
    endtask

    task automatic rd(input string tag, input logic [8:0] a1, input logic [8:0] a2);
        address  = a1;
        address2 = a2;
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
        #1;
        chk({tag, ".out"}, out, exp_q.pop_front());
        chk({tag, ".out2"}, out2, exp_q.pop_front());
        step();
    endtask

    task automatic wait_busy(input string tag, input int exp_edges);
        int n = 0;
        while (busy && n < 600) begin
            step();
            n++;
        end
        chk(tag, n, exp_edges);
    endtask

    initial begin
        int n;
        reset = 1'b1; load = 1'b1; clear = 1'b0;
        in = -16'sd12321; address = '0; address2 = '0;
        reset8 = 1'b1; load8 = 1'b0; clear8 = 1'b0;
        in8 = '0; address8 = '0; address2_8 = '0;
        for (int i = 0; i < 512; i++) model[i] = '0;

        // Reset held, then released with a load pending that must be ignored.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy, 1);
        chk("rst.out", out, 0);
        chk("rst.busy8", busy8, 1);
        reset = 1'b0;
        n = 0;
        while (busy && n < 600) begin
            step();
            n++;
            if (n == 256) chk("init.out_mid", out, 0);
        end
        chk("init.busy_len", n, 512);
        chk("init.mem0", out, 0);
        load = 1'b0;

        // Signed values at both ends of the array.
        wr(9'd0, -16'sd12321);
        wr(9'd511, 16'sd12321);
        rd("ends", 9'd0, 9'd511);
        chk("ends.neg_raw", out, 16'hCFDF);
        rd("unwritten", 9'd1, 9'd1);

        // Old value before the write edge, new value right after, on both ports.
        address = 9'd10; address2 = 9'd10; in = 16'sd12321; load = 1'b1;
        exp_q.push_back(model[10]);
        #1;
        chk("rdw.before", out2, exp_q.pop_front());
        step();
        load = 1'b0;
        model[10] = 16'sd12321;
        exp_q.push_back(model[10]);
        exp_q.push_back(model[10]);
        #1;
        chk("rdw.after_out2", out2, exp_q.pop_front());
        chk("rdw.after_out", out, exp_q.pop_front());
        chk("rdw.ports_equal", out, out2);
        step();

        // Fill with index, then clear while a load targets the same edge.
        for (int a = 0; a < 512; a++) wr(a[8:0], a[15:0]);
        rd("fill", 9'd5, 9'd300);
        rd("fill2", 9'd511, 9'd0);
        address = 9'd5; in = 16'h7777; load = 1'b1; clear = 1'b1;
        step();
        load = 1'b0; clear = 1'b0;
        chk("clr.busy_rise", busy, 1);
        wait_busy("clr.busy_len", 512);
        for (int i = 0; i < 512; i++) model[i] = '0;
        for (int a = 0; a < 512; a++) rd("clr.zero", a[8:0], 9'(511 - a));

        // Reset in the middle of a clear restarts the full sweep.
        wr(9'd300, 16'h1234);
        wr(9'd77, 16'h00AB);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (200) step();
        address = 9'd300;
        #1;
        chk("midclr.out_gated", out, 0);
        reset = 1'b1;
        #1;
        chk("midclr.busy", busy, 1);
        step();
        reset = 1'b0;
        wait_busy("midclr.busy_len", 512);
        model[300] = '0;
        model[77]  = '0;
        rd("midclr.zero", 9'd300, 9'd77);

        // Narrow instance.
        reset8 = 1'b0;
        n = 0;
        while (busy8 && n < 40) begin
            step();
            n++;
        end
        chk("small.busy_len", n, 16);
        address8 = 4'd15; in8 = 8'hA5; load8 = 1'b1;
        step();
        load8 = 1'b0;
        address2_8 = 4'd0;
        exp_q.push_back(16'h00A5);
        exp_q.push_back(16'h0000);
        #1;
        chk("small.out", {8'h00, out8}, exp_q.pop_front());
        chk("small.out2", {8'h00, out2_8}, exp_q.pop_front());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_clr.md
Name: ram_clr

Overview:
Parametrised successor to the fixed 16-bit x 512 Hack RAM. Single clock, synchronous write, two asynchronous read ports: the primary port follows the Hack in/load/address/out convention, and the second port is read-only. A built-in clear sequencer zeroes every word after reset or on request, and the block reports busy while clearing. Sits under the Hack memory map as data RAM, or as a scratch buffer for peripherals.

Parameters:
WIDTH, 16, data word width in bits.
AWIDTH, 9, address width; DEPTH = 2**AWIDTH words (derived, not overridable).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset; forces the sequencer to CLEAR.
in  input  WIDTH  write data (signed two's complement in benches).
load  input  1  write enable for port 1.
address  input  AWIDTH  port 1 read/write address.
out  output  WIDTH  port 1 read data.
address2  input  AWIDTH  port 2 read-only address.
out2  output  WIDTH  port 2 read data.
clear  input  1  synchronous request to re-zero the whole array.
busy  output  1  high while the clear sequencer owns the array.

Behaviour:
- State machine has two states: CLEAR and READY; clr_ptr is an AWIDTH-bit pointer.
- reset=1 (asynchronous): state=CLEAR, clr_ptr=0, busy=1. Memory contents are not touched by reset itself. out and out2 read 0 while busy.
- CLEAR: each posedge with reset=0 writes mem[clr_ptr]<=0 and increments clr_ptr.
  - The edge that writes clr_ptr==DEPTH-1 moves state to READY. clr_ptr wraps to 0.
  - busy falls after exactly DEPTH posedges following reset release.
- CLEAR: load is ignored; the write is dropped, not queued. clear is ignored.
- READY: at posedge, if clear=1, state goes to CLEAR, clr_ptr goes to 0, and busy rises after that edge. clear has priority over load in the same cycle, so the load is dropped.
- READY, load=1, clear=0: mem[address]<=in at posedge.
- Reads are combinational, out=mem[address] and out2=mem[address2], with Hack semantics:
  - out shows the old value until the write edge and the new value immediately after.
  - There is no write-to-read bypass within the same cycle.
- Both read ports may hit the same address, including the address being written. Both return identical data.
- Reset asserted mid-clear restarts the clear from address 0.
- Reset asserted coincident with a load edge: the write is lost.
- busy is a registered, glitch-free output: busy = (state==CLEAR).
- Address arithmetic is unsigned modulo DEPTH. There are no out-of-range addresses.

Decomposition:
- Shared package ram_pkg holds:
  - the state encoding (ST_CLEAR=1'b0, ST_READY=1'b1);
  - default WIDTH/AWIDTH constants (16/9) for Hack-compatible instances.
- Sub-module ram_clr_seq holds the FSM and clr_ptr. It takes clk, reset, clear and outputs busy, wr_en_clr and wr_addr_clr.
- The top level muxes the write port between the sequencer and the user and holds the storage array.

Test Plan:
- Reset pulse, then release with load=1, in=-12321, address=0 for all cycles -> busy=1 for exactly 512 posedges. out=0 throughout and mem[0] stays 0 (write ignored).
- After busy falls, write -12321 (0xCFDF) at address 0 and 12321 (0x3021) at 511. Then read with address=0 and address2=511 -> out=-12321, out2=12321. Unwritten address 1 -> 0.
- Write 12321 at 10 with address2=10 -> out2 holds the old value 0 before the edge and shows 12321 right after it. out and out2 are equal when address=address2=10.
- Fill addresses 0..511 with their index, then pulse clear with load=1 on the same edge -> busy for 512 cycles, the load dropped. All words read 0 afterwards.
- Reset asserted at clear cycle 200 and released -> busy lasts a further full 512 cycles. A word written before the first clear reads 0.
- Instance with WIDTH=8, AWIDTH=4: write 0xA5 at 15, then read at 15 and 0 -> 0xA5 and 0. busy lasts 16 cycles after reset.
